// File: rtl/bb_loop_filter.sv
// Bang-bang PI loop filter for the DCO: integrates early/late decisions,
// shifts gain down through COARSE/MEDIUM/FINE on direction reversals and flags lock.
module bb_loop_filter #(
    parameter int FILT_W    = 13,
    parameter int FRAC_W    = 6,
    parameter int INIT_CODE = 2432,
    parameter int OUT_MAX   = 4863,
    parameter int KI_C      = 4096,
    parameter int KI_M      = 512,
    parameter int KI_F      = 16,
    parameter int KP_C      = 32,
    parameter int KP_M      = 4,
    parameter int KP_F      = 1,
    parameter int TOGGLE_N  = 8,
    parameter int LOCK_N    = 16,
    parameter int RUN_N     = 4
) (
    input  logic              dco_clk,
    input  logic              reset,
    input  logic              comp_valid,
    input  logic              comp_up,
    input  logic              freeze,
    output logic [FILT_W-1:0] filter_output,
    output logic              filter_update,
    output logic [1:0]        gear,
    output logic              locked
);

    localparam int ACC_W = FILT_W + FRAC_W;
    localparam int SW    = ACC_W + 2;
    localparam int TOG_W = $clog2(LOCK_N + 1);
    localparam int RUN_W = $clog2(RUN_N + 1);

    localparam logic [ACC_W-1:0]     ACC_INIT  = ACC_W'(INIT_CODE * (2 ** FRAC_W));
    localparam logic [ACC_W-1:0]     ACC_MAX_U = ACC_W'(OUT_MAX * (2 ** FRAC_W));
    localparam logic signed [SW-1:0] ACC_MAX_S = SW'(OUT_MAX * (2 ** FRAC_W));
    localparam logic signed [SW-1:0] OUT_MAX_S = SW'(OUT_MAX);

    typedef enum logic [1:0] {
        COARSE = 2'd0,
        MEDIUM = 2'd1,
        FINE   = 2'd2,
        LOCKED = 2'd3
    } gear_t;

    function automatic logic [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] x);
        if (x < 0)              return '0;
        else if (x > ACC_MAX_S) return ACC_MAX_U;
        else                    return x[ACC_W-1:0];
    endfunction

    function automatic logic [FILT_W-1:0] sat_out(input logic signed [SW-1:0] x);
        if (x < 0)              return '0;
        else if (x > OUT_MAX_S) return FILT_W'(OUT_MAX);
        else                    return x[FILT_W-1:0];
    endfunction

    gear_t             gear_q, gear_d;
    logic [ACC_W-1:0]  int_acc_q, int_acc_d;
    logic [FILT_W-1:0] filter_output_q, filter_output_d;
    logic              filter_update_q, filter_update_d;
    logic              locked_q, locked_d;
    logic              prev_up_q, prev_up_d;
    logic              prev_vld_q, prev_vld_d;
    logic [TOG_W-1:0]  tog_cnt_q, tog_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;

    logic signed [SW-1:0] ki, kp, step_i, step_p, acc_sum, out_sum;
    logic [ACC_W-1:0]     int_n;
    logic [TOG_W-1:0]     tog_n;
    logic [RUN_W-1:0]     run_n;
    logic                 update, reversal;

    always_comb begin
        gear_d          = gear_q;
        int_acc_d       = int_acc_q;
        filter_output_d = filter_output_q;
        filter_update_d = 1'b0;
        locked_d        = locked_q;
        prev_up_d       = prev_up_q;
        prev_vld_d      = prev_vld_q;
        tog_cnt_d       = tog_cnt_q;
        run_cnt_d       = run_cnt_q;

        update   = comp_valid && !freeze;
        reversal = prev_vld_q && (comp_up != prev_up_q);

        // LOCKED keeps tracking with the FINE gains
        case (gear_q)
            COARSE:  begin ki = SW'(KI_C); kp = SW'(KP_C); end
            MEDIUM:  begin ki = SW'(KI_M); kp = SW'(KP_M); end
            default: begin ki = SW'(KI_F); kp = SW'(KP_F); end
        endcase
        step_i  = comp_up ? ki : -ki;
        step_p  = comp_up ? kp : -kp;
        acc_sum = $signed({2'b00, int_acc_q}) + step_i;
        int_n   = sat_acc(acc_sum);
        out_sum = $signed({{(SW-FILT_W){1'b0}}, int_n[ACC_W-1:FRAC_W]}) + step_p;

        if (reversal) begin
            tog_n = (tog_cnt_q == TOG_W'(LOCK_N)) ? tog_cnt_q : tog_cnt_q + 1'b1;
            run_n = '0;
        end else begin
            tog_n = '0;
            run_n = (run_cnt_q == RUN_W'(RUN_N)) ? run_cnt_q : run_cnt_q + 1'b1;
        end

        if (update) begin
            int_acc_d       = int_n;
            filter_output_d = sat_out(out_sum);
            filter_update_d = 1'b1;
            prev_up_d       = comp_up;
            prev_vld_d      = 1'b1;
            tog_cnt_d       = tog_n;
            run_cnt_d       = run_n;
            case (gear_q)
                COARSE: if (tog_n == TOG_W'(TOGGLE_N)) begin
                    gear_d    = MEDIUM;
                    tog_cnt_d = '0;
                end
                MEDIUM: if (tog_n == TOG_W'(TOGGLE_N)) begin
                    gear_d    = FINE;
                    tog_cnt_d = '0;
                end
                FINE: if (tog_n == TOG_W'(LOCK_N)) begin
                    gear_d   = LOCKED;
                    locked_d = 1'b1;
                end
                default: if (run_n == RUN_W'(RUN_N)) begin
                    gear_d    = MEDIUM;
                    locked_d  = 1'b0;
                    tog_cnt_d = '0;
                    run_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge dco_clk or posedge reset) begin
        if (reset) begin
            gear_q          <= COARSE;
            int_acc_q       <= ACC_INIT;
            filter_output_q <= FILT_W'(INIT_CODE);
            filter_update_q <= 1'b0;
            locked_q        <= 1'b0;
            prev_up_q       <= 1'b0;
            prev_vld_q      <= 1'b0;
            tog_cnt_q       <= '0;
            run_cnt_q       <= '0;
        end else begin
            gear_q          <= gear_d;
            int_acc_q       <= int_acc_d;
            filter_output_q <= filter_output_d;
            filter_update_q <= filter_update_d;
            locked_q        <= locked_d;
            prev_up_q       <= prev_up_d;
            prev_vld_q      <= prev_vld_d;
            tog_cnt_q       <= tog_cnt_d;
            run_cnt_q       <= run_cnt_d;
        end
    end

    assign filter_output = filter_output_q;
    assign filter_update = filter_update_q;
    assign gear          = gear_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_bb_loop_filter.sv
// Directed bench for bb_loop_filter: reset, gains, gear shifting, saturation,
// lock/unlock, freeze and asynchronous reset.
module tb_bb_loop_filter;

    logic        dco_clk = 1'b0;
    logic        reset;
    logic        comp_valid;
    logic        comp_up;
    logic        freeze;
    logic [12:0] filter_output;
    logic        filter_update;
    logic [1:0]  gear;
    logic        locked;

    int n_cmp = 0;
    int n_bad = 0;

    bb_loop_filter dut (
        .dco_clk      (dco_clk),
        .reset        (reset),
        .comp_valid   (comp_valid),
        .comp_up      (comp_up),
        .freeze       (freeze),
        .filter_output(filter_output),
        .filter_update(filter_update),
        .gear         (gear),
        .locked       (locked)
    );

    always #5 dco_clk = ~dco_clk;

    // one decision; returns 1 time unit after the sampling edge
    task automatic dec(input logic up);
        comp_up    = up;
        comp_valid = 1'b1;
        @(posedge dco_clk);
        #1;
        comp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        comp_valid = 1'b0;
        comp_up    = 1'b0;
        freeze     = 1'b0;
        repeat (2) @(posedge dco_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (filter_output !== 13'd2432) begin n_bad++; $display("FAIL reset_out: got %0d want 2432", filter_output); end
        n_cmp++; if (gear !== 2'd0) begin n_bad++; $display("FAIL reset_gear: got %0d want 0", gear); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
        n_cmp++; if (filter_update !== 1'b0) begin n_bad++; $display("FAIL reset_update: got %0b want 0", filter_update); end
    endtask

    task automatic test_first_update();
        do_reset();
        dec(1'b1);
        n_cmp++; if (filter_output !== 13'd2528) begin n_bad++; $display("FAIL first_out: got %0d want 2528", filter_output); end
        n_cmp++; if (filter_update !== 1'b1) begin n_bad++; $display("FAIL first_update_hi: got %0b want 1", filter_update); end
        @(posedge dco_clk); #1;
        n_cmp++; if (filter_update !== 1'b0) begin n_bad++; $display("FAIL first_update_lo: got %0b want 0", filter_update); end
        n_cmp++; if (filter_output !== 13'd2528) begin n_bad++; $display("FAIL first_hold: got %0d want 2528", filter_output); end
    endtask

    task automatic test_gear_shift();
        logic [1:0] exp_g;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            dec(i % 2 == 0);
            exp_g = (i == 8) ? 2'd1 : 2'd0;
            n_cmp++; if (gear !== exp_g) begin n_bad++; $display("FAIL shift_gear[%0d]: got %0d want %0d", i, gear, exp_g); end
        end
        n_cmp++; if (filter_output !== 13'd2528) begin n_bad++; $display("FAIL shift_out9: got %0d want 2528", filter_output); end
        dec(1'b1);
        n_cmp++; if (filter_output !== 13'd2508) begin n_bad++; $display("FAIL medium_gain: got %0d want 2508", filter_output); end
    endtask

    task automatic test_sat_high();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            dec(1'b1);
            if (i == 40 || i == 79) begin
                n_cmp++; if (filter_output !== 13'd4863) begin n_bad++; $display("FAIL sat_hi[%0d]: got %0d want 4863", i, filter_output); end
            end
        end
        n_cmp++; if (gear !== 2'd0) begin n_bad++; $display("FAIL sat_hi_gear: got %0d want 0", gear); end
        dec(1'b0);
        n_cmp++; if (filter_output !== 13'd4767) begin n_bad++; $display("FAIL sat_hi_down: got %0d want 4767", filter_output); end
    endtask

    task automatic test_sat_low();
        do_reset();
        for (int i = 0; i < 40; i++) dec(1'b0);
        n_cmp++; if (filter_output !== 13'd0) begin n_bad++; $display("FAIL sat_lo: got %0d want 0", filter_output); end
        dec(1'b1);
        n_cmp++; if (filter_output !== 13'd96) begin n_bad++; $display("FAIL sat_lo_up: got %0d want 96", filter_output); end
    endtask

    task automatic test_lock();
        logic [1:0] exp_g;
        do_reset();
        for (int n = 1; n <= 33; n++) begin
            dec(n % 2 == 0);
            exp_g = (n < 9) ? 2'd0 : (n < 17) ? 2'd1 : (n < 33) ? 2'd2 : 2'd3;
            n_cmp++; if (gear !== exp_g) begin n_bad++; $display("FAIL lock_gear[%0d]: got %0d want %0d", n, gear, exp_g); end
            n_cmp++; if (locked !== (n == 33)) begin n_bad++; $display("FAIL lock_flag[%0d]: got %0b want %0b", n, locked, n == 33); end
        end
        n_cmp++; if (filter_output !== 13'd2367) begin n_bad++; $display("FAIL lock_out: got %0d want 2367", filter_output); end
        for (int k = 1; k <= 4; k++) begin
            dec(1'b0);
            exp_g = (k < 4) ? 2'd3 : 2'd1;
            n_cmp++; if (gear !== exp_g) begin n_bad++; $display("FAIL unlock_gear[%0d]: got %0d want %0d", k, gear, exp_g); end
            n_cmp++; if (locked !== (k < 4)) begin n_bad++; $display("FAIL unlock_flag[%0d]: got %0b want %0b", k, locked, k < 4); end
            n_cmp++; if (filter_output !== 13'd2366) begin n_bad++; $display("FAIL unlock_out[%0d]: got %0d want 2366", k, filter_output); end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 0; i < 8; i++) dec(i % 2 == 0);
        n_cmp++; if (filter_output !== 13'd2400) begin n_bad++; $display("FAIL frz_pre: got %0d want 2400", filter_output); end
        comp_up    = 1'b1;
        comp_valid = 1'b1;
        freeze     = 1'b1;
        @(posedge dco_clk); #1;
        comp_valid = 1'b0;
        freeze     = 1'b0;
        n_cmp++; if (filter_update !== 1'b0) begin n_bad++; $display("FAIL frz_update: got %0b want 0", filter_update); end
        n_cmp++; if (filter_output !== 13'd2400) begin n_bad++; $display("FAIL frz_out: got %0d want 2400", filter_output); end
        n_cmp++; if (gear !== 2'd0) begin n_bad++; $display("FAIL frz_gear: got %0d want 0", gear); end
        dec(1'b1);
        n_cmp++; if (filter_update !== 1'b1) begin n_bad++; $display("FAIL frz_next_update: got %0b want 1", filter_update); end
        n_cmp++; if (filter_output !== 13'd2528) begin n_bad++; $display("FAIL frz_next_out: got %0d want 2528", filter_output); end
        n_cmp++; if (gear !== 2'd1) begin n_bad++; $display("FAIL frz_next_gear: got %0d want 1", gear); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 1; n <= 33; n++) dec(n % 2 == 0);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL ar_pre_locked: got %0b want 1", locked); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (filter_output !== 13'd2432) begin n_bad++; $display("FAIL ar_out: got %0d want 2432", filter_output); end
        n_cmp++; if (gear !== 2'd0) begin n_bad++; $display("FAIL ar_gear: got %0d want 0", gear); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL ar_locked: got %0b want 0", locked); end
        n_cmp++; if (filter_update !== 1'b0) begin n_bad++; $display("FAIL ar_update: got %0b want 0", filter_update); end
        #1;
        reset = 1'b0;
        @(posedge dco_clk); #1;
        dec(1'b1);
        n_cmp++; if (filter_output !== 13'd2528) begin n_bad++; $display("FAIL ar_after: got %0d want 2528", filter_output); end
    endtask

    initial begin
        reset      = 1'b1;
        comp_valid = 1'b0;
        comp_up    = 1'b0;
        freeze     = 1'b0;
        test_reset();
        test_first_update();
        test_gear_shift();
        test_sat_high();
        test_sat_low();
        test_lock();
        test_freeze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bb_loop_filter.md
Name: bb_loop_filter

Overview:
- Digital bang-bang PI loop filter with automatic gear shifting and lock detection.
- Sits directly upstream of the DCO decoder and drives its 13-bit filter_output code plus an update strobe.
- Input is one early/late decision per reference comparison from the phase comparator, already retimed into the dco_clk domain.
- Acquisition runs in three gains (coarse, medium, fine), then declares lock.

Parameters:
- FILT_W, 13, width of filter_output.
- FRAC_W, 6, fractional bits of the integrator.
- INIT_CODE, 2432, filter_output and integer part of the integrator after reset.
- OUT_MAX, 4863, maximum legal filter_output; keeps the decoder row code at 20 or below.
- KI_C / KI_M / KI_F, 4096 / 512 / 16, integrator step per decision in fractional units (64 / 8 / 0.25 LSB).
- KP_C / KP_M / KP_F, 32 / 4 / 1, proportional term in output LSB.
- TOGGLE_N, 8, consecutive direction reversals needed to shift down one gear.
- LOCK_N, 16, consecutive reversals in FINE needed to declare lock.
- RUN_N, 4, consecutive same-direction decisions in LOCKED that declare loss of lock.

Ports:
- dco_clk, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high.
- comp_valid, in, 1, one-cycle pulse: a new decision is present.
- comp_up, in, 1, decision: 1 = DCO slow (raise the code), 0 = DCO fast (lower the code); sampled only when comp_valid=1.
- freeze, in, 1, hold all state; decisions are ignored while high.
- filter_output, out, 13, registered DCO control code.
- filter_update, out, 1, one-cycle pulse when filter_output was just loaded.
- gear, out, 2, 0=COARSE, 1=MEDIUM, 2=FINE, 3=LOCKED.
- locked, out, 1, high only in the LOCKED state.

Behaviour:
- Clock and reset: one clock, dco_clk. Reset is asynchronous and active-high, on port reset.
- Reset values:
  - int_acc = INIT_CODE<<FRAC_W (19-bit unsigned).
  - filter_output = INIT_CODE; filter_update = 0; gear = 0; locked = 0.
  - prev_up = 0, prev_vld = 0, tog_cnt = 0, run_cnt = 0.
- Update occurs on a cycle with comp_valid=1 and freeze=0. Outputs are registered, so latency is 1 cycle: filter_output changes and filter_update pulses on the edge that samples comp_valid.
- Per-update arithmetic, using signed intermediates at least FILT_W+FRAC_W+2 bits wide:
  - s = +1 if comp_up else -1.
  - int_acc_n = clamp(int_acc + s*KI[gear], 0, OUT_MAX<<FRAC_W).
  - filter_output = clamp((int_acc_n>>FRAC_W) + s*KP[gear], 0, OUT_MAX).
  - In LOCKED, the FINE gains apply.
- Cycles with no update, or with freeze=1: all registers hold and filter_update=0.
- Reversal tracking:
  - A reversal is an update with prev_vld=1 and comp_up != prev_up.
  - On every update: prev_up <= comp_up, prev_vld <= 1.
  - A reversal increments tog_cnt, saturating at LOCK_N, and clears run_cnt.
  - A non-reversal clears tog_cnt and increments run_cnt, saturating at RUN_N.
- State machine; transitions are evaluated on the post-increment counts:
  - COARSE -> MEDIUM when tog_cnt reaches TOGGLE_N; tog_cnt cleared.
  - MEDIUM -> FINE when tog_cnt reaches TOGGLE_N; tog_cnt cleared.
  - FINE -> LOCKED when tog_cnt reaches LOCK_N; locked=1 on the same edge.
  - LOCKED -> MEDIUM when run_cnt reaches RUN_N; locked=0, both counters cleared.
  - No other transitions occur. Gains for an update are those of the state before the edge.
- Boundary conditions:
  - Integrator and output saturate at both ends and never wrap.
  - A decision at saturation still counts toward reversal and run tracking.
- Reset asserted mid-operation forces all reset values immediately, without waiting for dco_clk. An update pending on the same edge is lost.
- freeze and comp_valid high together: the decision is dropped and does not update prev_up.

Test Plan:
- Reset -> filter_output=2432, gear=0, locked=0, filter_update=0; then comp_valid with comp_up=1 -> next edge filter_output=2528 (2432+64+32), filter_update high for exactly 1 cycle.
- From reset, alternate up/down for 9 decisions -> after the 9th decision (8th reversal) gear=1; the next up decision adds 8 to the integrator and uses KP=4.
- 80 consecutive up decisions in COARSE -> filter_output saturates at 4863 and stays there; one down decision -> 4863-64-32 = 4767.
- Drive to FINE, then 16 reversals -> locked=1, gear=3; then 4 consecutive down decisions -> locked=0, gear=1 on the 4th update edge.
- comp_valid with freeze=1 -> no filter_update pulse, filter_output and counters unchanged; comp_valid with freeze=0 on the following cycle -> normal update.
- Assert reset between two dco_clk edges while in LOCKED with filter_output≠2432 -> outputs return to reset values before the next edge.
